// File: rtl/frame_swap_controller_if.sv
// rtl/frame_swap_controller_if.sv - renderer/scan-out bundle for frame_swap_controller
interface frame_swap_controller_if #(
  parameter int COORD_W = 10
);
  logic               flip;
  logic               vsync;
  logic               hsync_n;
  logic               vsync_n;
  logic               active;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               front_sel;
  logic               flip_pending;
  logic               flip_overrun;
  logic [7:0]         frame_count;

  modport master (
    input  flip,
    output vsync, hsync_n, vsync_n, active, x, y,
    output front_sel, flip_pending, flip_overrun, frame_count
  );

  modport slave (
    output flip,
    input  vsync, hsync_n, vsync_n, active, x, y,
    input  front_sel, flip_pending, flip_overrun, frame_count
  );
endinterface

// File: rtl/frame_swap_controller.sv
// rtl/frame_swap_controller.sv - raster timing plus front/back buffer swap on vblank
// FLIP_VSYNC_WAIT_EN defined: swaps wait for vblank; undefined: immediate swap on flip.
module frame_swap_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COORD_W  = 10
) (
  input logic                      clk,
  input logic                      resetn,
  frame_swap_controller_if.master  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_MAX  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_MAX  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               active_q, active_d;
  logic               hsync_n_q, hsync_n_d;
  logic               vsync_n_q, vsync_n_d;
  logic               vsync_q, vsync_d;
  logic               front_sel_q, front_sel_d;
  logic               flip_pending_q, flip_pending_d;
  logic               flip_overrun_q, flip_overrun_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic               flip_s_q, flip_q;
  logic               flip_rise;

  assign flip_rise = flip_s_q & ~flip_q;

  always_comb begin
    hc_d      = (hc_q == H_MAX) ? '0 : hc_q + COORD_W'(1);
    vc_d      = vc_q;
    if (hc_q == H_MAX) begin
      vc_d = (vc_q == V_MAX) ? '0 : vc_q + COORD_W'(1);
    end
    x_d       = hc_q;
    y_d       = vc_q;
    active_d  = (hc_q < H_ACT) && (vc_q < V_ACT);
    hsync_n_d = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    vsync_n_d = !((vc_q >= VS_BEG) && (vc_q < VS_END));
  end

`ifdef FLIP_VSYNC_WAIT_EN
  logic vblank_start;
  // Decoded on the counters so the swap lands on the same edge that shows (0, V_ACTIVE).
  assign vblank_start = (hc_q == '0) && (vc_q == V_ACT);

  always_comb begin
    vsync_d        = vblank_start;
    front_sel_d    = front_sel_q;
    frame_count_d  = frame_count_q;
    flip_pending_d = flip_pending_q;
    flip_overrun_d = flip_overrun_q;
    if (vblank_start && flip_pending_q) begin
      front_sel_d    = ~front_sel_q;
      frame_count_d  = frame_count_q + 8'd1;
      flip_pending_d = flip_rise;
    end else if (flip_rise) begin
      if (flip_pending_q) begin
        flip_overrun_d = 1'b1;
      end else begin
        flip_pending_d = 1'b1;
      end
    end
  end
`else
  always_comb begin
    vsync_d        = flip_rise;
    front_sel_d    = front_sel_q;
    frame_count_d  = frame_count_q;
    flip_pending_d = 1'b0;
    flip_overrun_d = 1'b0;
    if (flip_rise) begin
      front_sel_d   = ~front_sel_q;
      frame_count_d = frame_count_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hc_q           <= '0;
      vc_q           <= '0;
      x_q            <= '0;
      y_q            <= '0;
      active_q       <= 1'b0;
      hsync_n_q      <= 1'b1;
      vsync_n_q      <= 1'b1;
      vsync_q        <= 1'b0;
      front_sel_q    <= 1'b0;
      flip_pending_q <= 1'b0;
      flip_overrun_q <= 1'b0;
      frame_count_q  <= '0;
      flip_s_q       <= 1'b0;
      flip_q         <= 1'b0;
    end else begin
      hc_q           <= hc_d;
      vc_q           <= vc_d;
      x_q            <= x_d;
      y_q            <= y_d;
      active_q       <= active_d;
      hsync_n_q      <= hsync_n_d;
      vsync_n_q      <= vsync_n_d;
      vsync_q        <= vsync_d;
      front_sel_q    <= front_sel_d;
      flip_pending_q <= flip_pending_d;
      flip_overrun_q <= flip_overrun_d;
      frame_count_q  <= frame_count_d;
      flip_s_q       <= bus.flip;
      flip_q         <= flip_s_q;
    end
  end

  assign bus.vsync        = vsync_q;
  assign bus.hsync_n      = hsync_n_q;
  assign bus.vsync_n      = vsync_n_q;
  assign bus.active       = active_q;
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.front_sel    = front_sel_q;
  assign bus.flip_pending = flip_pending_q;
  assign bus.flip_overrun = flip_overrun_q;
  assign bus.frame_count  = frame_count_q;
endmodule

// File: tb/tb_frame_swap_controller.sv
// tb/tb_frame_swap_controller.sv - scoreboard bench for frame_swap_controller, small 7x6 raster
module tb_frame_swap_controller;
  logic clk;
  logic resetn;

  frame_swap_controller_if #(.COORD_W(4)) bus ();

  frame_swap_controller #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COORD_W(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       fs;
    logic [7:0] fc;
    logic       pend;
  } rec_t;

  rec_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc_cnt      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto(input int ex, input int ey);
    int  n;
    bit  found;
    n = 0;
    found = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.x == 4'(ex) && bus.y == 4'(ey)) found = 1;
    end
    if (!found) check("goto_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input int ex, input int ey, input logic fs, input int fc, input logic pend);
    rec_t r;
    r.x = 4'(ex); r.y = 4'(ey); r.fs = fs; r.fc = 8'(fc); r.pend = pend;
    exp_q.push_back(r);
  endtask

  // Monitor: every vsync strobe must match the oldest queued expectation.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (bus.vsync === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("vsync_unexpected", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("vsync_rec", 32'({bus.x, bus.y, bus.front_sel, bus.frame_count, bus.flip_pending}), 32'(r));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] reset_vec();
    return 32'({bus.x, bus.y, bus.active, bus.hsync_n, bus.vsync_n, bus.vsync,
                bus.front_sel, bus.flip_pending, bus.flip_overrun, bus.frame_count});
  endfunction

  localparam logic [31:0] RESET_EXP = 32'({4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

  initial begin
    int hs_low, act_cnt, vs_cnt, vs_first, vs_second, ex, ey, p;
    resetn   = 1'b0;
    bus.flip = 1'b0;
    cyc(3);
    check("reset_state", reset_vec(), RESET_EXP);

    // Raster: 84 cycles = two frames
`ifdef FLIP_VSYNC_WAIT_EN
    push(0, 3, 1'b0, 0, 1'b0);
    push(0, 3, 1'b0, 0, 1'b0);
`endif
    resetn = 1'b1;
    hs_low = 0; act_cnt = 0; vs_cnt = 0; vs_first = 0; vs_second = 0;
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      p  = (k - 1) % 42;
      ex = p % 7;
      ey = p / 7;
      check("raster", 32'({bus.x, bus.y, bus.active, bus.hsync_n, bus.vsync_n}),
            32'({4'(ex), 4'(ey), (ex < 4 && ey < 3), (ex != 5), (ey != 4)}));
      if (!bus.hsync_n) hs_low++;
      if (bus.active) act_cnt++;
      if (bus.vsync) begin
        vs_cnt++;
        if (vs_cnt == 1) vs_first = k; else vs_second = k;
      end
    end
    check("hsync_low_count", 32'(hs_low), 32'd12);
    check("active_count", 32'(act_cnt), 32'd24);
`ifdef FLIP_VSYNC_WAIT_EN
    check("vsync_count", 32'(vs_cnt), 32'd2);
    check("vsync_period", 32'(vs_second - vs_first), 32'd42);

    // Single flip in frame 2
    goto(1, 0);
    push(0, 3, 1'b1, 1, 1'b0);
    bus.flip = 1'b1;
    cyc(1);
    check("pending_after_1_edge", 32'(bus.flip_pending), 32'd0);
    cyc(1);
    check("pending_after_2_edges", 32'(bus.flip_pending), 32'd1);
    bus.flip = 1'b0;

    // Overrun: two flips in frame 3
    goto(1, 0);
    push(0, 3, 1'b0, 2, 1'b0);
    bus.flip = 1'b1;
    cyc(2);
    check("overrun_pending", 32'(bus.flip_pending), 32'd1);
    bus.flip = 1'b0;
    cyc(2);
    bus.flip = 1'b1;
    cyc(1);
    check("overrun_not_yet", 32'(bus.flip_overrun), 32'd0);
    cyc(1);
    check("overrun_set", 32'(bus.flip_overrun), 32'd1);
    bus.flip = 1'b0;
    goto(0, 4);
    check("overrun_after_swap", 32'({bus.flip_overrun, bus.flip_pending, bus.frame_count}), 32'({1'b1, 1'b0, 8'd2}));

    // Collision: flip_rise on the vblank edge of frame 4, served in frame 5
    push(0, 3, 1'b0, 2, 1'b1);
    push(0, 3, 1'b1, 3, 1'b0);
    goto(5, 2);
    bus.flip = 1'b1;
    cyc(1);
    check("collision_pre_pending", 32'(bus.flip_pending), 32'd0);
    cyc(3);
    bus.flip = 1'b0;
    goto(6, 5);
    check("overrun_sticky", 32'(bus.flip_overrun), 32'd1);
    goto(0, 4);

    // Pending flip at y=2 of frame 6, then reset
    goto(1, 0);
    bus.flip = 1'b1;
    cyc(2);
    check("pre_reset_state", 32'({bus.flip_pending, bus.front_sel}), 32'({1'b1, 1'b1}));
    bus.flip = 1'b0;
`else
    check("vsync_count", 32'(vs_cnt), 32'd0);

    // Immediate flips: ack 2 edges after flip rises, none at vblank
    goto(0, 1);
    push(2, 1, 1'b1, 1, 1'b0);
    bus.flip = 1'b1;
    cyc(1);
    check("imm_no_toggle_yet", 32'({bus.front_sel, bus.vsync}), 32'd0);
    cyc(2);
    bus.flip = 1'b0;
    goto(0, 4);
    goto(3, 4);
    push(5, 4, 1'b0, 2, 1'b0);
    bus.flip = 1'b1;
    cyc(3);
    bus.flip = 1'b0;
    goto(0, 1);
    push(2, 1, 1'b1, 3, 1'b0);
    bus.flip = 1'b1;
    cyc(3);
    bus.flip = 1'b0;
    check("imm_pending_tied", 32'({bus.flip_pending, bus.flip_overrun}), 32'd0);
    check("pre_reset_state", 32'(bus.front_sel), 32'd1);
`endif

    goto(0, 2);
    resetn = 1'b0;
    #1;
    check("async_reset", reset_vec(), RESET_EXP);
    cyc(2);
    check("reset_held", reset_vec(), RESET_EXP);
`ifdef FLIP_VSYNC_WAIT_EN
    push(0, 3, 1'b0, 0, 1'b0);
`endif
    resetn = 1'b1;
    cyc(60);
    check("post_reset_no_swap", 32'({bus.front_sel, bus.frame_count, bus.flip_pending}), 32'd0);

    cyc(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
